alu_result_serializer: RTL and testbench

Transmit-side companion to the 8-bit result register. The block accepts one registered ALU result word through a ready/load handshake. It shifts the word out on a single serial line as a framed bit stream: start bit, data LSB-first, optional parity, then stop bit. It sits downstream of the result register and is the read-out path of the ALU core.

---
 rtl/alu_result_serializer_pkg.sv | 5 +
 rtl/alu_result_serializer_if.sv | 11 +
 rtl/alu_result_serializer_timer.sv | 17 +
 rtl/alu_result_serializer.sv | 94 +++++++++
 tb/tb_alu_result_serializer.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/alu_result_serializer_pkg.sv
// alu_pkg: shared state encoding and line constants for the ALU result serializer.
package alu_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} ser_state_t;
  localparam logic SER_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/alu_result_serializer_if.sv
// alu_result_serializer_if: load handshake and serial output bundle.
interface alu_result_serializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] DATA;
  logic             LOAD;
  logic             READY;
  logic             BUSY;
  logic             SDO;
  logic             DONE;
  modport master (output DATA, LOAD, input READY, BUSY, SDO, DONE);
  modport slave  (input DATA, LOAD, output READY, BUSY, SDO, DONE);
endinterface

// File: rtl/alu_result_serializer_timer.sv
// ser_bit_timer: per-bit down-counter; tick marks the last cycle of each serial bit.
module ser_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic restart_i,
  output logic tick_o
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == '0;
  always_comb cnt_d = (restart_i || tick_o) ? CW'(CLKS_PER_BIT - 1) : cnt_q - CW'(1);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/alu_result_serializer.sv
// alu_result_serializer: framed LSB-first serial transmitter for the ALU result word.
// Define ALU_SER_PARITY_EN to insert an even-parity bit before the stop bit.
module alu_result_serializer
  import alu_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input logic CLK,
  input logic RST,
  alu_result_serializer_if.slave bus
);
  localparam int BW = $clog2(WIDTH);
  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             sdo_q, sdo_d, done_q, done_d, ready_q, ready_d, tick;
`ifdef ALU_SER_PARITY_EN
  logic             par_q, par_d;
`endif
  ser_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .restart_i(state_q == IDLE),
    .tick_o   (tick)
  );
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.LOAD) begin
        state_d = START;
        shift_d = bus.DATA;
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + BW'(1);
        if (bit_q == BW'(WIDTH - 1)) begin
          bit_d = '0;
`ifdef ALU_SER_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef ALU_SER_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP: if (tick) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are derived from the next state so they can be registered without lag.
    ready_d = state_d == IDLE;
    sdo_d   = (state_d == START) ? 1'b0 :
              (state_d == DATA)  ? shift_d[0] :
`ifdef ALU_SER_PARITY_EN
              (state_d == PARITY) ? par_q :
`endif
              SER_IDLE_LEVEL;
  end
`ifdef ALU_SER_PARITY_EN
  always_comb par_d = (state_q == IDLE && bus.LOAD) ? ^bus.DATA : par_q;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) par_q <= 1'b0;
    else par_q <= par_d;
`endif
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      sdo_q   <= SER_IDLE_LEVEL;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      sdo_q   <= sdo_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  assign bus.SDO   = sdo_q;
  assign bus.DONE  = done_q;
  assign bus.READY = ready_q;
  assign bus.BUSY  = ~ready_q;
endmodule

// File: tb/tb_alu_result_serializer.sv
// tb_alu_result_serializer: table-driven frame checks plus a word-level scoreboard.
module tb_alu_result_serializer;
  localparam int W   = 8;
  localparam int CPB = 4;
`ifdef ALU_SER_PARITY_EN
  localparam int NB = W + 3;
`else
  localparam int NB = W + 2;
`endif
  localparam int F = NB * CPB;
  typedef struct {
    logic [W-1:0] data;
    logic         par;
  } vec_t;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb[$];
  vec_t vecs[8];
  int mcyc = 0;
  int mb;
  logic [W-1:0] mword = '0;
  alu_result_serializer_if #(.WIDTH(W)) bus ();
  alu_result_serializer #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic frame_bit(input logic [W-1:0] d, input logic par, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= W) return d[idx-1];
    if (idx == W + 1 && NB == W + 3) return par;
    return 1'b1;
  endfunction
  // Scoreboard monitor: rebuilds each word from mid-bit samples and pops on DONE.
  always @(negedge CLK) begin
    if (!RST) mcyc = 0;
    else begin
      if (bus.BUSY) begin
        mcyc++;
        mb = (mcyc - 1) / CPB;
        if ((mcyc - 1) % CPB == CPB / 2 && mb >= 1 && mb <= W) mword[mb-1] = bus.SDO;
      end
      if (bus.DONE) begin
        if (sb.size() == 0) check("sb_unexpected_frame", {24'b0, mword}, 32'hDEAD);
        else check("sb_word", {24'b0, mword}, {24'b0, sb.pop_front()});
        mcyc = 0;
      end
    end
  end
  task automatic wait_ready();
    for (int i = 0; i < 4 * F; i++) begin
      if (bus.READY) return;
      @(negedge CLK);
    end
    check("ready_timeout", 0, 1);
  endtask
  task automatic run_frame(input logic [W-1:0] d, input logic par, input bit poke);
    wait_ready();
    @(negedge CLK);
    bus.LOAD = 1'b1;
    bus.DATA = d;
    sb.push_back(d);
    for (int c = 1; c <= F + 1; c++) begin
      @(negedge CLK);
      if (c == 1) bus.LOAD = 1'b0;
      if (c == 2) bus.DATA = W'($urandom);
      if (poke && c == 5) begin
        bus.LOAD = 1'b1;
        bus.DATA = '1;
      end
      if (poke && c == 20) bus.LOAD = 1'b0;
      check("sdo", bus.SDO, (c <= F) ? frame_bit(d, par, (c - 1) / CPB) : 1'b1);
      check("done", bus.DONE, c == F + 1);
      check("ready", bus.READY, c == F + 1);
      check("busy", bus.BUSY, c != F + 1);
    end
  endtask
  initial begin
    int d1, d2, cnt;
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h3C, 1'b0};
    vecs[3] = '{8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b0};
    vecs[5] = '{8'h01, 1'b1};
    vecs[6] = '{8'h80, 1'b1};
    vecs[7] = '{8'h5A, 1'b0};
    bus.LOAD = 1'b0;
    bus.DATA = '0;
    #2 RST = 1'b0;
    #1;
    check("rst_sdo", bus.SDO, 1'b1);
    check("rst_ready", bus.READY, 1'b1);
    check("rst_busy", bus.BUSY, 1'b0);
    check("rst_done", bus.DONE, 1'b0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    foreach (vecs[i]) run_frame(vecs[i].data, vecs[i].par, 1'b0);
    run_frame(8'h3C, 1'b0, 1'b1);
    cnt = 0;
    repeat (2 * F) begin
      @(negedge CLK);
      if (bus.BUSY) cnt++;
    end
    check("no_second_frame", cnt, 0);
    wait_ready();
    @(negedge CLK);
    bus.LOAD = 1'b1;
    bus.DATA = 8'h01;
    sb.push_back(8'h01);
    d1 = 0;
    d2 = 0;
    for (int c = 1; c <= 3 * F && d2 == 0; c++) begin
      @(negedge CLK);
      if (c == 2) bus.DATA = 8'h80;
      if (d1 != 0 && c == d1 + 1) begin
        bus.LOAD = 1'b0;
        check("b2b_start_bit", bus.SDO, 1'b0);
        check("b2b_reaccepted", bus.READY, 1'b0);
      end
      if (bus.DONE) begin
        if (d1 == 0) begin
          d1 = c;
          sb.push_back(8'h80);
        end else d2 = c;
      end
    end
    bus.LOAD = 1'b0;
    check("b2b_done1_cycle", d1, F + 1);
    check("b2b_done_spacing", d2 - d1, F + 1);
    wait_ready();
    @(negedge CLK);
    bus.LOAD = 1'b1;
    bus.DATA = 8'h55;
    sb.push_back(8'h55);
    for (int c = 1; c <= 1 + 4 * CPB + 1; c++) begin
      @(negedge CLK);
      if (c == 1) bus.LOAD = 1'b0;
    end
    check("abort_bit3_low", bus.SDO, 1'b0);
    #2 RST = 1'b0;
    #1;
    check("abort_sdo", bus.SDO, 1'b1);
    check("abort_ready", bus.READY, 1'b1);
    check("abort_busy", bus.BUSY, 1'b0);
    check("abort_done", bus.DONE, 1'b0);
    void'(sb.pop_back());
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    cnt = 0;
    repeat (F + 8) begin
      @(negedge CLK);
      if (bus.DONE || bus.BUSY) cnt++;
    end
    check("abort_no_activity", cnt, 0);
    run_frame(8'h0F, 1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
